button_seq_controller: RTL
==========================

Name: button_seq_controller

Overview:
- Sequencing controller for the lab board's push-button/LED path.
- Synchronizes and debounces the four active-low buttons, converts presses into one-cycle events, and runs the INIT/ALPHA/BRAVO/CHARLIE state machine.
- Drives the active-low LED bank, a state-change strobe and a saturating invalid-press counter.
- Sits between the board button pins and the LED pins, on the clock derived from the differential system clock.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive clk edges a synchronized button level must differ from the debounced level before the debounced level is accepted. Minimum 1.
- BLINK_DIV, 8: clk cycles per LED blink half-period in CHARLIE. Minimum 1.

Ports:
- clk  input  1: single clock, derived from sys_clkp/sys_clkn upstream; all logic on the rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- button  input  4: raw board buttons, active-low (0 = pressed), asynchronous to clk.
- led  output  8: LED drive, active-low (0 = lit), registered.
- state  output  2: current state; INIT=0, ALPHA=1, BRAVO=2, CHARLIE=3.
- state_change  output  1: one-cycle pulse on the edge the state register changes value.
- err_cnt  output  4: count of ignored presses, saturates at 15.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - synchronizer flops and debounced levels to 1 (released); debounce counters to 0;
  - state=INIT, led=8'hFF, state_change=0, err_cnt=0, blink counter 0, blink phase 0.
  - Reset mid-debounce or mid-blink discards all progress. First evaluation occurs on the first clk edge after rst_n rises.
- Synchronizer: 2-flop per bit. A raw change sampled at edge k is visible at stage 2 after edge k+1.
- Debounce, per bit:
  - If synced == debounced, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 with synced != debounced, debounced <= synced and counter <= 0.
  - Any reversion before that clears the counter, so glitches shorter than DEBOUNCE_CYCLES edges are filtered.
- Press event: press[i] is asserted combinationally for the one cycle after debounced[i] goes 1->0. Releases generate no event.
- Latency: raw press stable from edge k → debounced falls at edge k+1+DEBOUNCE_CYCLES → state updates at edge k+2+DEBOUNCE_CYCLES, with state_change=1 for that cycle.
- Same-cycle press priority: button[1] > button[2] > button[3] > button[0]. Only the winning press is evaluated; losing presses are discarded and do not count as errors.
- Transitions:
  - button[1]: any state → INIT. If already INIT, no state change and no error.
  - button[2]: INIT→ALPHA, BRAVO→CHARLIE. From ALPHA or CHARLIE: ignored, counts as error.
  - button[3]: INIT→BRAVO, ALPHA→CHARLIE. From BRAVO or CHARLIE: ignored, counts as error.
  - button[0]: never transitions; always counts as error.
- err_cnt increments by 1 per error event; holds at 15, no wrap.
- LED, registered with the state (same edge):
  - INIT 8'hFF; ALPHA 8'hFE; BRAVO 8'hFD.
  - CHARLIE alternates 8'hF0 / 8'hFF. Phase starts at 8'hF0 on CHARLIE entry and toggles every BLINK_DIV cycles.
  - Blink counter and phase clear whenever state != CHARLIE.
- Buttons held continuously produce exactly one press event. A new event requires a debounced release followed by a debounced press.

Test Plan (DEBOUNCE_CYCLES=2, BLINK_DIV=4, 10 ns clk):
- Reset: rst_n=0 for 30 ns with button=4'b1111 → state=0, led=8'hFF, err_cnt=0, state_change=0; all remain so for 200 ns after release.
- Path INIT→ALPHA→CHARLIE→INIT: drive 1011 for 60 ns, 1111 for 60 ns, 0111 for 60 ns, 1111 for 60 ns, 1101 for 60 ns.
  - Required: state 1, 3, 0 in turn; led FE, then blinking F0/FF (toggle every 40 ns), then FF.
  - Each state update is exactly 4 edges after the press edge; three state_change pulses.
- Path INIT→BRAVO→CHARLIE: 0111 then 1011, each 60 ns separated by 60 ns of 1111 → state 2 (led FD), then state 3.
- Glitch filter: button[2] low for 10 ns only → no state change, no error.
- Errors: in BRAVO, press button[3] three times and button[0] twice → state stays 2, err_cnt=5. Twenty error presses → err_cnt=15.
- Simultaneous press plus reset mid-operation:
  - In ALPHA, drive 4'b0001 → state 0 (button[1] wins), err_cnt unchanged.
  - Assert rst_n mid-blink → state=0, led=8'hFF, err_cnt=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/button_seq_controller.sv
// Push-button sequencing controller: sync + debounce of four active-low buttons,
// press-event extraction, INIT/ALPHA/BRAVO/CHARLIE state machine, LED drive,
// state-change strobe and saturating invalid-press counter.
module button_seq_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned BLINK_DIV       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] button,
  output logic [7:0] led,
  output logic [1:0] state,
  output logic       state_change,
  output logic [3:0] err_cnt
);

  localparam int unsigned NB      = 4;
  localparam int unsigned DB_CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BL_CW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned ERR_W   = 4;
  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_CW-1:0] BL_LAST = BL_CW'(BLINK_DIV - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  localparam logic [7:0] LED_INIT  = 8'hFF;
  localparam logic [7:0] LED_ALPHA = 8'hFE;
  localparam logic [7:0] LED_BRAVO = 8'hFD;
  localparam logic [7:0] LED_ON    = 8'hF0;
  localparam logic [7:0] LED_OFF   = 8'hFF;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_ALPHA   = 2'd1,
    S_BRAVO   = 2'd2,
    S_CHARLIE = 2'd3
  } state_t;

  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    db;
  logic [NB-1:0]    db_prev;
  logic [DB_CW-1:0] db_cnt [NB];
  logic [NB-1:0]    press_c;

  state_t           state_q;
  state_t           state_d;
  logic [BL_CW-1:0] blink_cnt_q;
  logic [BL_CW-1:0] blink_cnt_d;
  logic             blink_ph_q;
  logic             blink_ph_d;
  logic [7:0]       led_d;
  logic [ERR_W-1:0] err_d;
  logic             chg_d;
  logic             err_ev;

  // Two-flop synchronizer; released (1) is the safe reset level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: accept a new level only after it persists long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db      <= '1;
      db_prev <= '1;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      db_prev <= db;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_CW'(1);
        end
      end
    end
  end

  // One-cycle press event on a debounced 1->0 transition.
  assign press_c = db_prev & ~db;

  // State, LED, strobe, error counter and blink registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      led          <= LED_INIT;
      state_change <= 1'b0;
      err_cnt      <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      led          <= led_d;
      state_change <= chg_d;
      err_cnt      <= err_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
    end
  end

  // Next-state, error and LED decode; button[1] > [2] > [3] > [0].
  always_comb begin
    state_d     = state_q;
    err_ev      = 1'b0;
    err_d       = err_cnt;
    chg_d       = 1'b0;
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    led_d       = LED_INIT;

    if (press_c[1]) begin
      state_d = S_INIT;
    end else if (press_c[2]) begin
      case (state_q)
        S_INIT:  state_d = S_ALPHA;
        S_BRAVO: state_d = S_CHARLIE;
        default: err_ev  = 1'b1;
      endcase
    end else if (press_c[3]) begin
      case (state_q)
        S_INIT:  state_d = S_BRAVO;
        S_ALPHA: state_d = S_CHARLIE;
        default: err_ev  = 1'b1;
      endcase
    end else if (press_c[0]) begin
      err_ev = 1'b1;
    end

    if (err_ev && (err_cnt != ERR_MAX)) err_d = err_cnt + ERR_W'(1);

    chg_d = (state_d != state_q);

    // Blink timing only runs while staying in CHARLIE; entry restarts at LED_ON.
    if ((state_d == S_CHARLIE) && (state_q == S_CHARLIE)) begin
      if (blink_cnt_q == BL_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BL_CW'(1);
        blink_ph_d  = blink_ph_q;
      end
    end

    case (state_d)
      S_INIT:    led_d = LED_INIT;
      S_ALPHA:   led_d = LED_ALPHA;
      S_BRAVO:   led_d = LED_BRAVO;
      S_CHARLIE: led_d = blink_ph_d ? LED_OFF : LED_ON;
      default:   led_d = LED_INIT;
    endcase
  end

  assign state = state_q;

endmodule
